// File: rtl/ycr_wb_burst_split.sv
// rtl/ycr_wb_burst_split.sv - burst-to-single-beat wishbone splitter with no-ack watchdog
module ycr_wb_burst_split #(
  parameter int WB_WIDTH = 32,
  parameter int BL_W     = 10,
  parameter int TO_W     = 8
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic                s_cyc_i,
  input  logic                s_stb_i,
  input  logic [WB_WIDTH-1:0] s_adr_i,
  input  logic                s_we_i,
  input  logic [WB_WIDTH-1:0] s_dat_i,
  input  logic [3:0]          s_sel_i,
  input  logic [BL_W-1:0]     s_bl_i,
  input  logic                s_bry_i,
  output logic [WB_WIDTH-1:0] s_dat_o,
  output logic                s_ack_o,
  output logic                s_lack_o,
  output logic                s_err_o,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic [WB_WIDTH-1:0] m_adr_o,
  output logic                m_we_o,
  output logic [WB_WIDTH-1:0] m_dat_o,
  output logic [3:0]          m_sel_o,
  input  logic [WB_WIDTH-1:0] m_dat_i,
  input  logic                m_ack_i,
  input  logic                m_err_i
);

  typedef enum logic [1:0] {IDLE, BEAT, RESP, DONE} state_t;

  // Watchdog fires on the last of 2**TO_W-1 strobed cycles (counter starts at 0).
  localparam logic [TO_W-1:0] WD_LAST = TO_W'((2 ** TO_W) - 2);

  state_t              state;
  state_t              state_nxt;
  logic [WB_WIDTH-1:0] adr_q;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [BL_W-1:0]     beats_left;
  logic [TO_W-1:0]     wd_cnt;

  logic                req;
  logic                timeout;
  logic                beat_go;
  logic                term_err;
  logic                term_ack;
  logic [BL_W-1:0]     bl_eff;

  assign req      = s_cyc_i && s_stb_i;
  assign timeout  = (wd_cnt == WD_LAST);
  assign beat_go  = (state == BEAT) && !m_stb_o && s_bry_i;
  // Slave error beats everything; a real ack on the watchdog's last cycle still counts.
  assign term_err = (state == BEAT) && m_stb_o && (m_err_i || (timeout && !m_ack_i));
  assign term_ack = (state == BEAT) && m_stb_o && m_ack_i && !m_err_i;
  assign bl_eff   = (s_bl_i == '0) ? BL_W'(1) : s_bl_i;

  // State register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BEAT;
      BEAT:    if (term_err || term_ack) state_nxt = RESP;
      RESP:    state_nxt = (beats_left != '0) ? BEAT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, beat issue, termination capture and one-cycle upstream response
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      beats_left <= '0;
      wd_cnt     <= '0;
      s_dat_o    <= '0;
      s_ack_o    <= 1'b0;
      s_lack_o   <= 1'b0;
      s_err_o    <= 1'b0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_adr_o    <= '0;
      m_we_o     <= 1'b0;
      m_dat_o    <= '0;
      m_sel_o    <= '0;
    end else begin
      s_ack_o  <= 1'b0;
      s_lack_o <= 1'b0;
      s_err_o  <= 1'b0;
      s_dat_o  <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            adr_q      <= s_adr_i;
            we_q       <= s_we_i;
            sel_q      <= s_sel_i;
            beats_left <= bl_eff;
          end
        end
        BEAT: begin
          if (beat_go) begin
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_adr_o <= adr_q;
            m_we_o  <= we_q;
            m_sel_o <= sel_q;
            m_dat_o <= we_q ? s_dat_i : '0;
            wd_cnt  <= '0;
          end else if (term_err) begin
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            s_ack_o    <= 1'b1;
            s_lack_o   <= 1'b1;
            s_err_o    <= 1'b1;
            beats_left <= '0;
          end else if (term_ack) begin
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            s_ack_o    <= 1'b1;
            s_lack_o   <= (beats_left == BL_W'(1));
            s_dat_o    <= we_q ? '0 : m_dat_i;
            adr_q      <= adr_q + WB_WIDTH'(4);
            beats_left <= beats_left - BL_W'(1);
          end else if (m_stb_o) begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
